// File: rtl/gf_pkg.sv
// gf_pkg: shared types and helpers for the carry-less (GF(2)[x]) divider.
// Holds the controller state enum, the step-counter width and the single
// bit-serial long-division step used by both the radix-2 and radix-4 datapaths.
package gf_pkg;

  localparam int GF_W     = 32;
  localparam int GF_KW    = $clog2(GF_W);
  localparam int GF_CNT_W = $clog2(2 * GF_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cl_state_e;

  typedef struct packed {
    logic [GF_W-1:0] r;
    logic            qbit;
  } gf_step_t;

  // One long-division step: bring down the next dividend bit, and subtract
  // (xor) the divisor when the new partial remainder reaches degree k.
  // deg(r) < k always holds, so the top bit of t never becomes set.
  function automatic gf_step_t gf_step(input logic [GF_W-1:0]  r,
                                       input logic             b,
                                       input logic [GF_W-1:0]  d,
                                       input logic [GF_KW-1:0] k);
    logic [GF_W:0] t;
    gf_step_t      res;
    t        = {r, b};
    res.qbit = t[k];
    if (res.qbit) begin
      t = t ^ {1'b0, d};
    end
    res.r = t[GF_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/cl_divider_deg_enc.sv
// cl_deg_enc: priority encoder returning the index of the highest set bit
// (the polynomial degree) plus a flag for the all-zero vector.
module cl_deg_enc #(
  parameter int W  = 32,
  parameter int KW = $clog2(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [KW-1:0] o_deg,
  output logic          o_zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    o_deg  = '0;
    o_zero = ~|i_vec;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) begin
        o_deg = KW'(i);
      end
    end
  end

endmodule

// File: rtl/cl_divider.sv
// cl_divider: sequential carry-less polynomial divider (dividend 2W bits,
// divisor W bits), MSB-first long division behind a start/done handshake.
// Optional feature macro CL_DIV_RADIX4_EN: two division steps per RUN cycle,
// halving latency from 2W to W cycles. Undefined: one step per cycle.
// The step helper in gf_pkg is sized by GF_W, so DATA_WIDTH must equal GF_W.
module cl_divider
  import gf_pkg::*;
#(
  parameter int DATA_WIDTH = GF_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0]   divisor,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0]   remainder,
  output logic                    div_by_zero
);

  localparam int DW = DATA_WIDTH;
  localparam int SW = 2 * DATA_WIDTH;
  localparam int KW = $clog2(DATA_WIDTH);
`ifdef CL_DIV_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam int                  N_CYC    = SW / STEPS;
  localparam logic [GF_CNT_W-1:0] LAST_CNT = GF_CNT_W'(N_CYC - 1);

  cl_state_e           r_state;
  cl_state_e           w_state_nx;
  logic                w_accept;
  logic                w_last;

  // r_s holds the unconsumed dividend bits at the top and collects quotient
  // bits at the bottom; after the final step it is exactly the quotient.
  logic [SW-1:0]       r_s;
  logic [SW-1:0]       w_s_nx;
  logic [DW-1:0]       r_d;
  logic [DW-1:0]       r_part;
  logic [DW-1:0]       w_part_nx;
  logic [KW-1:0]       r_k;
  logic [KW-1:0]       w_deg;
  logic                w_zero;
  logic                r_dbz;
  logic [GF_CNT_W-1:0] r_cnt;
  logic [SW-1:0]       r_quot;
  logic [DW-1:0]       r_rem;

  cl_deg_enc #(
    .W  (DW),
    .KW (KW)
  ) u_deg_enc (
    .i_vec  (divisor),
    .o_deg  (w_deg),
    .o_zero (w_zero)
  );

`ifdef CL_DIV_RADIX4_EN
  gf_step_t w_st0;
  gf_step_t w_st1;

  // Two chained division steps per cycle.
  always_comb begin
    w_st0     = gf_step(r_part, r_s[SW-1], r_d, r_k);
    w_st1     = gf_step(w_st0.r, r_s[SW-2], r_d, r_k);
    w_part_nx = w_st1.r;
    w_s_nx    = {r_s[SW-3:0], w_st0.qbit, w_st1.qbit};
  end
`else
  gf_step_t w_st0;

  // One division step per cycle.
  always_comb begin
    w_st0     = gf_step(r_part, r_s[SW-1], r_d, r_k);
    w_part_nx = w_st0.r;
    w_s_nx    = {r_s[SW-2:0], w_st0.qbit};
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; a zero divisor spends one RUN cycle and performs no steps.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        w_last = r_dbz || (r_cnt == LAST_CNT);
        if (w_last) begin
          w_state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = RUN;
        end else begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Operand capture on accept, then one (or two) steps per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_d    <= '0;
      r_k    <= '0;
      r_dbz  <= 1'b0;
      r_part <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_s    <= dividend;
      r_d    <= divisor;
      r_k    <= w_deg;
      r_dbz  <= w_zero;
      r_part <= '0;
      r_cnt  <= '0;
    end else if (r_state == RUN && !r_dbz) begin
      r_s    <= w_s_nx;
      r_part <= w_part_nx;
      r_cnt  <= r_cnt + GF_CNT_W'(1);
    end
  end

  // Result registers update only on completion so they hold between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
    end else if (w_last) begin
      if (r_dbz) begin
        r_quot <= '0;
        r_rem  <= '0;
      end else begin
        r_quot <= w_s_nx;
        r_rem  <= w_part_nx;
      end
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_cl_divider.sv
// tb_cl_divider: directed self-checking bench for cl_divider.
module tb_cl_divider;

  localparam int W = 32;
`ifdef CL_DIV_RADIX4_EN
  localparam int LAT = W;
`else
  localparam int LAT = 2 * W;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [2*W-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  int total = 0;
  int bad   = 0;

  cl_divider #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Stimulus only: accept one operation, then count edges until done (-1 on timeout).
  task automatic do_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv, output int lat);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 64'hA5A5_A5A5_5A5A_5A5A;
    divisor  = 32'h5A5A_C3C3;
    lat = 0;
    while (done !== 1'b1 && lat < 4 * LAT) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b dbz=%b q=%h r=%h required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_vectors();
    logic [2*W-1:0] tdd [7] = '{64'h78, 64'h545, 64'h100, 64'hFFFF,
                                64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5};
    logic [W-1:0]   tdv [7] = '{32'hA, 32'h16, 32'h11B, 32'h3, 32'h1, 32'h8000_0000, 32'h11B};
    logic [2*W-1:0] tq  [7] = '{64'hC, 64'h4E, 64'h1, 64'h5555,
                                64'h0123_4567_89AB_CDEF, 64'h1_FFFF_FFFF, 64'h0};
    logic [W-1:0]   tr  [7] = '{32'h0, 32'h1, 32'h1B, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h5};
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(tdd[i], tdv[i], lat);
      total++;
      if (lat !== LAT) begin
        bad++;
        $display("FAIL vec%0d_latency: got %0d required %0d", i, lat, LAT);
      end
      total++;
      if (quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_result: q=%h r=%h dbz=%b required q=%h r=%h dbz=0",
                 i, quotient, remainder, div_by_zero, tq[i], tr[i]);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || quotient !== tq[i] || remainder !== tr[i]) begin
        bad++;
        $display("FAIL vec%0d_pulse_hold: done=%b q=%h r=%h required done=0 q=%h r=%h",
                 i, done, quotient, remainder, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_zero_div();
    int lat;
    do_op(64'hDEAD, 32'h0, lat);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL zero_latency: got %0d required 1", lat);
    end
    total++;
    if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL zero_result: q=%h r=%h dbz=%b required q=0 r=0 dbz=1",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL zero_hold: done=%b dbz=%b required done=0 dbz=1", done, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(64'h545, 32'h16, lat);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL b2b_first_latency: got %0d required %0d", lat, LAT);
    end
    // Issued while in DONE: second done lands LAT+1 cycles after the first.
    do_op(64'h78, 32'hA, lat);
    total++;
    if (lat !== LAT || quotient !== 64'hC || remainder !== 32'h0) begin
      bad++;
      $display("FAIL b2b_second: lat=%0d q=%h r=%h required lat=%0d q=c r=0",
               lat, quotient, remainder, LAT);
    end
    do_op(64'h100, 32'h0, lat);
    total++;
    if (lat !== 1 || div_by_zero !== 1'b1 || quotient !== '0) begin
      bad++;
      $display("FAIL b2b_zero: lat=%0d dbz=%b q=%h required lat=1 dbz=1 q=0",
               lat, div_by_zero, quotient);
    end
    do_op(64'h100, 32'h11B, lat);
    total++;
    if (lat !== LAT || div_by_zero !== 1'b0 || quotient !== 64'h1 || remainder !== 32'h1B) begin
      bad++;
      $display("FAIL b2b_after_zero: lat=%0d dbz=%b q=%h r=%h required lat=%0d dbz=0 q=1 r=1b",
               lat, div_by_zero, quotient, remainder, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int n;
    dividend = 64'h545; divisor = 32'h16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 4 * LAT) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n == 1) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_high: got %b required 1", busy);
        end
      end
      if (n == 3 || n == LAT - 5) begin
        start = 1'b1; dividend = 64'hFFFF; divisor = 32'h3;
      end
    end
    start = 1'b0;
    total++;
    if (n !== LAT || quotient !== 64'h4E || remainder !== 32'h1) begin
      bad++;
      $display("FAIL busy_ignore: lat=%0d q=%h r=%h required lat=%0d q=4e r=1",
               n, quotient, remainder, LAT);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL busy_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    dividend = 64'hFFFF; divisor = 32'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: busy=%b done=%b dbz=%b q=%h r=%h required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done cycles required 0", seen);
    end
    do_op(64'hFFFF, 32'h3, lat);
    total++;
    if (lat !== LAT || quotient !== 64'h5555 || remainder !== 32'h0) begin
      bad++;
      $display("FAIL abort_restart: lat=%0d q=%h r=%h required lat=%0d q=5555 r=0",
               lat, quotient, remainder, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_zero_div();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
